// File: rtl/led7_scan_ctrl.sv
// led7_scan_ctrl: time-multiplexed scan controller for the alarm clock's
// seven-segment display. One digit at a time owns the shared BCD decoder;
// each digit slot starts with a short blanked guard gap to prevent ghosting.
// Digit data and masks are snapshotted once per frame so a frame never tears.
// Optional feature macro: LEADING_ZERO_BLANK_EN (dark hour-tens digit when 0).
module led7_scan_ctrl #(
  parameter int NUM_DIGITS   = 6,
  parameter int SCAN_DIV     = 50000,
  parameter int GUARD_CYCLES = 1,
  parameter int BLINK_DIV    = 25
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] digits_bcd,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  input  logic                    display_on,
  output logic [3:0]              bcd_out,
  output logic                    dec_enable,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic                    frame_tick
);

  localparam int PRE_W  = $clog2(SCAN_DIV);
  localparam int SLOT_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int FCNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [PRE_W-1:0]  PRE_MAX  = PRE_W'(SCAN_DIV - 1);
  localparam logic [PRE_W-1:0]  GUARD    = PRE_W'(GUARD_CYCLES);
  localparam logic [SLOT_W-1:0] SLOT_MAX = SLOT_W'(NUM_DIGITS - 1);
  localparam logic [FCNT_W-1:0] FCNT_MAX = FCNT_W'(BLINK_DIV - 1);

  logic [PRE_W-1:0]        pre;
  logic [SLOT_W-1:0]       slot;
  logic [FCNT_W-1:0]       fcnt;
  logic                    blink_phase;
  logic [4*NUM_DIGITS-1:0] digits_s;
  logic [NUM_DIGITS-1:0]   blink_s;
  logic [NUM_DIGITS-1:0]   blank_s;
  logic                    frame_edge_q;

  logic                    pre_end;
  logic                    slot_end;
  logic                    frame_end;
  logic [3:0]              cur_bcd;
  logic                    cur_blink;
  logic                    cur_blank;
  logic [NUM_DIGITS-1:0]   sel_onehot;
  logic                    vis;

  assign pre_end   = (pre == PRE_MAX);
  assign slot_end  = (slot == SLOT_MAX);
  assign frame_end = pre_end & slot_end;

  // Scan counters, per-frame snapshot and blink phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre          <= '0;
      slot         <= '0;
      fcnt         <= '0;
      blink_phase  <= 1'b0;
      digits_s     <= '0;
      blink_s      <= '0;
      blank_s      <= '0;
      frame_edge_q <= 1'b0;
    end else begin
      if (pre_end) begin
        pre  <= '0;
        slot <= slot_end ? '0 : slot + SLOT_W'(1);
      end else begin
        pre <= pre + PRE_W'(1);
      end
      if (frame_end) begin
        digits_s <= digits_bcd;
        blink_s  <= blink_mask;
        blank_s  <= blank_mask;
        if (fcnt == FCNT_MAX) begin
          fcnt        <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          fcnt <= fcnt + FCNT_W'(1);
        end
      end
      // Delayed once more at the outputs so the tick lines up with the
      // first output cycle of slot 0 under the new snapshot.
      frame_edge_q <= frame_end;
    end
  end

  // Select the current slot's snapshot data and decide visibility.
  always_comb begin
    cur_bcd    = 4'd0;
    cur_blink  = 1'b0;
    cur_blank  = 1'b0;
    sel_onehot = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (slot == SLOT_W'(i)) begin
        cur_bcd       = digits_s[4*i +: 4];
        cur_blink     = blink_s[i];
        cur_blank     = blank_s[i];
        sel_onehot[i] = 1'b1;
      end
    end
    vis = display_on & ~cur_blank & ~(cur_blink & blink_phase) & (pre >= GUARD);
`ifdef LEADING_ZERO_BLANK_EN
    if (slot_end && (cur_bcd == 4'd0)) begin
      vis = 1'b0;
    end
`else
`endif
  end

  // Register the pin outputs one cycle behind the scan state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_sel  <= '1;
      dec_enable <= 1'b0;
      bcd_out    <= 4'd0;
      frame_tick <= 1'b0;
    end else begin
      digit_sel  <= vis ? ~sel_onehot : '1;
      dec_enable <= vis;
      bcd_out    <= cur_bcd;   // BCD 10-15 passes through; decoder blanks it
      frame_tick <= frame_edge_q;
    end
  end

endmodule
